// File: rtl/lsu_pkg.sv
//------------------------------------------------------------------------------
// lsu_pkg
// Shared constants and types for the load/store unit: data/address widths,
// access-size encodings and the control FSM state enum.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  // Access size encodings carried on req_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

endpackage

`default_nettype wire

// File: rtl/load_store_unit_if.sv
//------------------------------------------------------------------------------
// load_store_unit_if
// Core-side request/response handshake of the load/store unit.
//   master : the core (drives req_*, receives req_ready and resp_*)
//   slave  : the load/store unit
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface load_store_unit_if;
  import lsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );

endinterface

`default_nettype wire

// File: rtl/lsu_lane_align.sv
//------------------------------------------------------------------------------
// lsu_lane_align
// Combinational little-endian lane logic.
//   word_i      : 32-bit word read from memory
//   offset_i    : byte offset within the word (addr[1:0])
//   size_i      : access size (byte/half/word)
//   signed_i    : sign-extend the extracted load value
//   wdata_i     : right-aligned store data
//   load_val_o  : extracted and extended load value
//   merged_o    : word_i with the target lane replaced by wdata_i
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsu_lane_align
  import lsu_pkg::*;
(
  input  wire logic [DATA_W-1:0] word_i,
  input  wire logic [1:0]        offset_i,
  input  wire logic [1:0]        size_i,
  input  wire logic              signed_i,
  input  wire logic [DATA_W-1:0] wdata_i,
  output logic      [DATA_W-1:0] load_val_o,
  output logic      [DATA_W-1:0] merged_o
);

  logic [4:0]        byte_sh;
  logic [4:0]        half_sh;
  logic [DATA_W-1:0] byte_word;
  logic [DATA_W-1:0] half_word;

  // Half lanes sit on 16-bit boundaries, so only offset[1] selects them.
  assign byte_sh   = {offset_i, 3'b000};
  assign half_sh   = {offset_i[1], 4'b0000};
  assign byte_word = word_i >> byte_sh;
  assign half_word = word_i >> half_sh;

  always_comb begin
    load_val_o = word_i;
    merged_o   = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_val_o = {{24{signed_i & byte_word[7]}}, byte_word[7:0]};
        merged_o   = (word_i & ~(32'h0000_00FF << byte_sh))
                   | ({24'h0, wdata_i[7:0]} << byte_sh);
      end
      SZ_HALF: begin
        load_val_o = {{16{signed_i & half_word[15]}}, half_word[15:0]};
        merged_o   = (word_i & ~(32'h0000_FFFF << half_sh))
                   | ({16'h0, wdata_i[15:0]} << half_sh);
      end
      default: begin
        load_val_o = word_i;
        merged_o   = wdata_i;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
//------------------------------------------------------------------------------
// load_store_unit
// Initiator side of the data-memory interface. Accepts one load/store per
// handshake, checks size/alignment/range, drives the memory strobes and
// returns extended load data. Sub-word stores are read-modify-write.
//   clock, reset_n : clock and asynchronous active-low reset
//   core           : request/response handshake (slave modport)
//   MemRead/MemWrite/Address/WriteData : memory control and write path
//   ReadData       : combinational read data from memory
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  wire logic              clock,
  input  wire logic              reset_n,
  load_store_unit_if.slave       core,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic [ADDR_W-1:0]      Address,
  output logic [DATA_W-1:0]      WriteData,
  input  wire logic [DATA_W-1:0] ReadData
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_WORDS * 4);

  lsu_state_e        state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;   // store data, later the merged word
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              req_err;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] merged;

  always_comb begin
    req_err = 1'b0;
    if (core.req_size == SZ_RSVD)                                    req_err = 1'b1;
    if ((core.req_size == SZ_HALF) && core.req_addr[0])              req_err = 1'b1;
    if ((core.req_size == SZ_WORD) && (core.req_addr[1:0] != 2'b00)) req_err = 1'b1;
    if (core.req_addr >= ADDR_LIMIT)                                 req_err = 1'b1;
  end

  lsu_lane_align u_lane_align (
    .word_i     (ReadData),
    .offset_i   (addr_q[1:0]),
    .size_i     (size_q),
    .signed_i   (signed_q),
    .wdata_i    (wdata_q),
    .load_val_o (load_val),
    .merged_o   (merged)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      write_q  <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (core.req_valid) begin
          write_d  = core.req_write;
          size_d   = core.req_size;
          signed_d = core.req_signed;
          addr_d   = core.req_addr;
          wdata_d  = core.req_wdata;
          rdata_d  = '0;
          err_d    = req_err;
          if (req_err)
            state_d = ST_RESP;
          else if (core.req_write && (core.req_size == SZ_WORD))
            state_d = ST_WR;
          else
            state_d = ST_RD;   // loads and the read half of read-modify-write
        end
      end
      ST_RD: begin
        if (write_q) begin
          wdata_d = merged;
          state_d = ST_WR;
        end else begin
          rdata_d = load_val;
          state_d = ST_RESP;
        end
      end
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // All outputs decode registered state only.
  assign core.req_ready  = (state_q == ST_IDLE);
  assign core.resp_valid = (state_q == ST_RESP);
  assign core.resp_err   = (state_q == ST_RESP) & err_q;
  assign core.resp_rdata = (state_q == ST_RESP) ? rdata_q : '0;

  assign MemRead   = (state_q == ST_RD);
  assign MemWrite  = (state_q == ST_WR);
  assign Address   = ((state_q == ST_RD) || (state_q == ST_WR)) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign WriteData = (state_q == ST_WR) ? wdata_q : '0;

endmodule

`default_nettype wire
